// File: rtl/ahbl_arbiter_if.sv
// Bundle of upstream (src_*) and downstream (dst_*) AHB-lite signals around the N:1 arbiter.
// The slave modport is the arbiter's view. The master modport is the surrounding fabric's view.
interface ahbl_arbiter_if #(
    parameter int N_PORTS = 2,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32
);
    logic [N_PORTS-1:0]        src_hready;
    logic [N_PORTS-1:0]        src_hready_resp;
    logic [N_PORTS-1:0]        src_hresp;
    logic [N_PORTS*W_ADDR-1:0] src_haddr;
    logic [N_PORTS-1:0]        src_hwrite;
    logic [N_PORTS*2-1:0]      src_htrans;
    logic [N_PORTS*3-1:0]      src_hsize;
    logic [N_PORTS*3-1:0]      src_hburst;
    logic [N_PORTS*4-1:0]      src_hprot;
    logic [N_PORTS-1:0]        src_hmastlock;
    logic [N_PORTS*W_DATA-1:0] src_hwdata;
    logic [N_PORTS*W_DATA-1:0] src_hrdata;
    logic [N_PORTS-1:0]        src_hexcl;
    logic [N_PORTS*8-1:0]      src_hmaster;
    logic [N_PORTS-1:0]        src_hexokay;

    logic                      dst_hready;
    logic                      dst_hready_resp;
    logic                      dst_hresp;
    logic [W_ADDR-1:0]         dst_haddr;
    logic                      dst_hwrite;
    logic [1:0]                dst_htrans;
    logic [2:0]                dst_hsize;
    logic [2:0]                dst_hburst;
    logic [3:0]                dst_hprot;
    logic                      dst_hmastlock;
    logic [W_DATA-1:0]         dst_hwdata;
    logic [W_DATA-1:0]         dst_hrdata;
    logic                      dst_hexcl;
    logic [7:0]                dst_hmaster;
    logic                      dst_hexokay;

    modport slave (
        input  src_hready, src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst,
               src_hprot, src_hmastlock, src_hwdata, src_hexcl, src_hmaster,
               dst_hready_resp, dst_hresp, dst_hrdata, dst_hexokay,
        output src_hready_resp, src_hresp, src_hrdata, src_hexokay,
               dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst,
               dst_hprot, dst_hmastlock, dst_hwdata, dst_hexcl, dst_hmaster
    );

    modport master (
        output src_hready, src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst,
               src_hprot, src_hmastlock, src_hwdata, src_hexcl, src_hmaster,
               dst_hready_resp, dst_hresp, dst_hrdata, dst_hexokay,
        input  src_hready_resp, src_hresp, src_hrdata, src_hexokay,
               dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst,
               dst_hprot, dst_hmastlock, dst_hwdata, dst_hexcl, dst_hmaster
    );
endinterface

// File: rtl/ahbl_arbiter.sv
// AHB-lite N:1 arbiter with a fixed priority (port 0 is highest) and locked-sequence support.
// Each losing address phase is parked in a per-port buffer, and that master is stalled until its transfer completes.
module ahbl_arbiter #(
    parameter int N_PORTS = 2,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32
) (
    input logic          clk,
    input logic          rst_n,
    ahbl_arbiter_if.slave bus
);
    localparam int W_IDX = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef struct packed {
        logic [W_ADDR-1:0] haddr;
        logic              hwrite;
        logic [1:0]        htrans;
        logic [2:0]        hsize;
        logic [2:0]        hburst;
        logic [3:0]        hprot;
        logic              hmastlock;
        logic              hexcl;
        logic [7:0]        hmaster;
    } addr_phase_t;

    addr_phase_t        live_ph [N_PORTS];
    addr_phase_t        eff_ph  [N_PORTS];
    addr_phase_t        buf_reg [N_PORTS];
    addr_phase_t        sel_ph;

    logic [N_PORTS-1:0] live, req, elig, gnt, issue, park;
    logic [N_PORTS-1:0] buf_valid_reg, stalled_d_reg, gnt_d_reg;
    logic               lock_valid_reg;
    logic [W_IDX-1:0]   lock_owner_reg;
    logic [W_IDX-1:0]   gnt_idx;
    logic               gnt_any;
    logic               accept;
    logic [W_DATA-1:0]  hwdata_mux;

    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
            // Gating with rst_n means a master that holds NONSEQ through reset is not forwarded.
            assign live[gi]    = rst_n & bus.src_htrans[2*gi+1] & bus.src_hready[gi];
            assign live_ph[gi] = '{
                haddr:     bus.src_haddr[gi*W_ADDR +: W_ADDR],
                hwrite:    bus.src_hwrite[gi],
                htrans:    bus.src_htrans[gi*2 +: 2],
                hsize:     bus.src_hsize[gi*3 +: 3],
                hburst:    bus.src_hburst[gi*3 +: 3],
                hprot:     bus.src_hprot[gi*4 +: 4],
                hmastlock: bus.src_hmastlock[gi],
                hexcl:     bus.src_hexcl[gi],
                hmaster:   bus.src_hmaster[gi*8 +: 8]
            };
            assign eff_ph[gi] = buf_valid_reg[gi] ? buf_reg[gi] : live_ph[gi];
            assign req[gi]    = buf_valid_reg[gi] | live[gi];
            assign elig[gi]   = req[gi] & (~lock_valid_reg | (lock_owner_reg == W_IDX'(gi)));
            assign gnt[gi]    = gnt_any & (gnt_idx == W_IDX'(gi));
            assign issue[gi]  = accept & gnt[gi];
            assign park[gi]   = live[gi] & ~issue[gi];

            // Responses use only registered state and the dst inputs, never src_htrans.
            assign bus.src_hready_resp[gi] = gnt_d_reg[gi] ? bus.dst_hready_resp
                                                           : ~(buf_valid_reg[gi] | stalled_d_reg[gi]);
            assign bus.src_hresp[gi]       = gnt_d_reg[gi] & bus.dst_hresp;
            assign bus.src_hexokay[gi]     = gnt_d_reg[gi] & bus.dst_hexokay;
            assign bus.src_hrdata[gi*W_DATA +: W_DATA] = bus.dst_hrdata;
        end
    endgenerate

    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (elig[i]) begin
                gnt_idx = W_IDX'(i);
                gnt_any = 1'b1;
            end
        end
    end

    assign accept = gnt_any & bus.dst_hready_resp;
    assign sel_ph = eff_ph[gnt_idx];

    always_comb begin
        hwdata_mux = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (gnt_d_reg[i]) begin
                hwdata_mux = hwdata_mux | bus.src_hwdata[i*W_DATA +: W_DATA];
            end
        end
    end

    assign bus.dst_hready    = bus.dst_hready_resp;
    assign bus.dst_htrans    = gnt_any ? sel_ph.htrans : 2'b00;
    assign bus.dst_haddr     = sel_ph.haddr;
    assign bus.dst_hwrite    = sel_ph.hwrite;
    assign bus.dst_hsize     = sel_ph.hsize;
    assign bus.dst_hburst    = sel_ph.hburst;
    assign bus.dst_hprot     = sel_ph.hprot;
    assign bus.dst_hmastlock = sel_ph.hmastlock;
    assign bus.dst_hexcl     = sel_ph.hexcl;
    assign bus.dst_hmaster   = sel_ph.hmaster;
    assign bus.dst_hwdata    = hwdata_mux;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_reg  <= '0;
            stalled_d_reg  <= '0;
            gnt_d_reg      <= '0;
            lock_valid_reg <= 1'b0;
            lock_owner_reg <= '0;
        end else begin
            stalled_d_reg <= park;
            buf_valid_reg <= (buf_valid_reg & ~issue) | park;
            if (bus.dst_hready_resp) begin
                gnt_d_reg <= issue;
            end
            // The owner's first unlocked accepted transfer ends the locked sequence.
            if (accept) begin
                lock_valid_reg <= sel_ph.hmastlock;
                lock_owner_reg <= gnt_idx;
            end
        end
    end

    // Buffer contents are only meaningful while the matching bit of buf_valid_reg is set, so they need no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_PORTS; i++) begin
            if (park[i]) begin
                buf_reg[i] <= live_ph[i];
            end
        end
    end
endmodule
